ddr5_cmd_sequencer: RTL and testbench
=====================================

# ddr5_cmd_sequencer

Closed-page DDR5 command sequencer that sits directly downstream of the scheduler request queue. It takes one address-mapped request at a time and emits its two-cycle DDR5 command sequence, ACT → RD/WR → PRE, on a registered command bus. All inter-command spacing is enforced with internal counters. It also services refresh requests between transactions.

## Interface
Parameters (all values in `clock` cycles):
- `T_RCD`, 39, cycles from ACT0 to RD0/WR0; must be ≥2
- `T_RTP`, 18, cycles from RD0 to PRE; must be ≥2
- `T_CWL`, 38, write CAS latency, counted from WR0
- `T_BURST`, 8, data burst length
- `T_WR`, 30, write recovery after the burst ends
- `T_RP`, 39, cycles from PRE to the next ACT0 or REF; must be ≥2
- `T_RFC`, 295, cycles from REF to the next ACT0 or REF; must be ≥2

Ports:
- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request available at queue head
- `req_ready`  out  1  sequencer can accept a request this cycle
- `req_op`  in  2  0 = data read, 1 = write, 2 = instruction fetch (treated as read); 3 is illegal
- `req_bg`  in  3  bank group
- `req_bank`  in  2  bank
- `req_row`  in  16  row
- `req_col`  in  8  column
- `ref_req`  in  1  refresh request, level; held until acknowledged
- `ref_ack`  out  1  one-cycle pulse, coincident with REF issue
- `cmd_valid`  out  1  a command is present on the bus this cycle
- `cmd`  out  4  0 NOP, 1 ACT0, 2 ACT1, 3 RD0, 4 RD1, 5 WR0, 6 WR1, 7 PRE, 8 REF
- `cmd_bg` / `cmd_bank`  out  3/2  target bank
- `cmd_row`  out  16  row field
- `cmd_col`  out  8  column field
- `done`  out  1  one-cycle pulse, coincident with PRE issue
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- States: IDLE, ACT0, ACT1, WAIT_RCD, CAS0, CAS1, WAIT_PRE, PRE, WAIT_RP, REF, WAIT_RFC.
- `req_ready` = (state==IDLE) && !ref_req. It is combinational from registered state.
- Accept when `req_valid && req_ready`. Fields are latched into internal registers on that edge.
- Refresh has priority: if IDLE and `ref_req`=1, go to REF and ignore `req_valid`.
- Read or fetch sequence: ACT0, ACT1, WAIT_RCD, RD0, RD1, WAIT_PRE, PRE, WAIT_RP, IDLE.
- Write sequence: the same path with WR0/WR1 in place of RD0/RD1.
- Refresh sequence: REF, WAIT_RFC, IDLE.
- A single down-counter is loaded at ACT0, RD0/WR0, PRE and REF. Wait states exit when the counter expires.
- Illegal `req_op`=3 is accepted and executed as a read.
- Field driving rules (all outputs registered):
  - `cmd_bg`/`cmd_bank` are driven for every command except REF and NOP, where they are 0.
  - `cmd_row` is driven only during ACT0/ACT1, otherwise 0.
  - `cmd_col` is driven only during RD0/RD1/WR0/WR1, otherwise 0.
- `cmd_valid` = (cmd != NOP).

## Timing
- Acceptance edge at cycle c puts ACT0 on the bus in cycle c+1. Let a be the ACT0 cycle.
- Command spacing:
  - ACT1 at a+1.
  - RD0/WR0 at a+T_RCD; RD1/WR1 the following cycle. Let r be the RD0/WR0 cycle.
  - Read PRE at p = r+T_RTP.
  - Write PRE at p = r+T_CWL+T_BURST+T_WR.
- `req_ready` can rise no earlier than cycle p+T_RP−1, so the next ACT0 is at ≥ p+T_RP.
- For REF at cycle f: `req_ready` can rise no earlier than f+T_RFC−1. A pending `ref_req` may issue the next REF at f+T_RFC.
- Reset values: state IDLE, counter 0, `cmd`=NOP, `cmd_valid`/`done`/`ref_ack`/`busy`=0, all fields 0.
- `req_ready` is 0 while `reset` is asserted and equals !ref_req in the first cycle after release.
- Reset mid-sequence aborts immediately. No PRE is issued, and no `done` or `ref_ack` pulse is generated.
- `req_valid` dropping after acceptance has no effect.
- Input fields are sampled only on the acceptance edge.

## Test plan
Default test parameters: T_RCD=4, T_RTP=3, T_CWL=3, T_BURST=2, T_WR=5, T_RP=4, T_RFC=10. Accept at cycle 0 unless stated.
- Read (op=0, bg=2, bank=1, row=0x1234, col=0x56) → ACT0@1, ACT1@2 with row 0x1234; RD0@5, RD1@6 with col 0x56; PRE+`done`@8; `req_ready`@11.
- Write (op=1) → ACT0@1, ACT1@2, WR0@5, WR1@6, PRE@15, `req_ready`@18. A second request accepted @18 gives ACT0@19.
- `ref_req` and `req_valid` both high while IDLE → REF+`ref_ack`@1, `req_ready`=0 until @10, then the request's ACT0@11.
- `ref_req` raised at cycle 3 during a read → no effect until the read's WAIT_RP completes; REF issued @12, `req_ready` stays 0 throughout.
- `reset` pulsed at cycle 6 of a write → bus is NOP from cycle 7 onward with no PRE or `done`. `req_ready`=1 in the first cycle after release; a new read then runs the full read sequence.
- Back-to-back fetch (op=2) requests always valid → ACT0 spacing is exactly 11 cycles, and no command gap is shorter than its parameter.

Source files
------------

// File: rtl/ddr5_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ddr5_cmd_sequencer
// Description : Closed-page DDR5 command sequencer. Takes one address-mapped
//               request at a time and issues ACT0/ACT1, RD0/RD1 or WR0/WR1,
//               then PRE, on a registered command bus. Refresh requests are
//               serviced between transactions and take priority in IDLE.
//               One down-counter enforces all inter-command spacing.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset           sole clock, synchronous active-high reset
//   req_valid / req_ready  request handshake (ready = IDLE && !ref_req)
//   req_op                 0 read, 1 write, 2 fetch (read), 3 illegal (read)
//   req_bg/bank/row/col    request address fields, sampled on acceptance
//   ref_req / ref_ack      refresh level request / one-cycle ack with REF
//   cmd_valid, cmd         registered command bus (cmd_valid = cmd != NOP)
//   cmd_bg/bank/row/col    registered command fields, 0 when not driven
//   done                   one-cycle pulse coincident with PRE
//   busy                   high whenever the FSM is not in IDLE
// ============================================================================
module ddr5_cmd_sequencer #(
    parameter int T_RCD   = 39,
    parameter int T_RTP   = 18,
    parameter int T_CWL   = 38,
    parameter int T_BURST = 8,
    parameter int T_WR    = 30,
    parameter int T_RP    = 39,
    parameter int T_RFC   = 295
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_bg,
    input  logic [1:0]  req_bank,
    input  logic [15:0] req_row,
    input  logic [7:0]  req_col,
    input  logic        ref_req,
    output logic        ref_ack,
    output logic        cmd_valid,
    output logic [3:0]  cmd,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_row,
    output logic [7:0]  cmd_col,
    output logic        done,
    output logic        busy
);

    // The bus is registered from the next state, so every wait ends one
    // cycle before the following command appears. Loads into ACT/CAS waits
    // are therefore "gap - 1". PRE and REF waits end in IDLE, which itself
    // occupies one cycle before the next ACT0/REF, hence "gap - 2".
    localparam int C_L_RCD  = T_RCD - 1;
    localparam int C_L_RPRE = T_RTP - 1;
    localparam int C_L_WPRE = T_CWL + T_BURST + T_WR - 1;
    localparam int C_L_RP   = T_RP - 2;
    localparam int C_L_RFC  = T_RFC - 2;

    localparam int C_M1    = (C_L_RCD  > C_L_RPRE) ? C_L_RCD : C_L_RPRE;
    localparam int C_M2    = (C_M1     > C_L_WPRE) ? C_M1    : C_L_WPRE;
    localparam int C_M3    = (C_M2     > C_L_RP)   ? C_M2    : C_L_RP;
    localparam int C_M4    = (C_M3     > C_L_RFC)  ? C_M3    : C_L_RFC;
    localparam int C_CNT_W = (C_M4 < 2) ? 1 : $clog2(C_M4 + 1);

    localparam logic [C_CNT_W-1:0] C_LD_RCD  = C_CNT_W'(C_L_RCD);
    localparam logic [C_CNT_W-1:0] C_LD_RPRE = C_CNT_W'(C_L_RPRE);
    localparam logic [C_CNT_W-1:0] C_LD_WPRE = C_CNT_W'(C_L_WPRE);
    localparam logic [C_CNT_W-1:0] C_LD_RP   = C_CNT_W'(C_L_RP);
    localparam logic [C_CNT_W-1:0] C_LD_RFC  = C_CNT_W'(C_L_RFC);

    localparam logic [3:0] C_CMD_NOP  = 4'd0;
    localparam logic [3:0] C_CMD_ACT0 = 4'd1;
    localparam logic [3:0] C_CMD_ACT1 = 4'd2;
    localparam logic [3:0] C_CMD_RD0  = 4'd3;
    localparam logic [3:0] C_CMD_RD1  = 4'd4;
    localparam logic [3:0] C_CMD_WR0  = 4'd5;
    localparam logic [3:0] C_CMD_WR1  = 4'd6;
    localparam logic [3:0] C_CMD_PRE  = 4'd7;
    localparam logic [3:0] C_CMD_REF  = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ACT0     = 4'd1,
        S_ACT1     = 4'd2,
        S_WAIT_RCD = 4'd3,
        S_CAS0     = 4'd4,
        S_CAS1     = 4'd5,
        S_WAIT_PRE = 4'd6,
        S_PRE      = 4'd7,
        S_WAIT_RP  = 4'd8,
        S_REF      = 4'd9,
        S_WAIT_RFC = 4'd10
    } state_e;

    state_e               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 accept;

    // Request fields captured on the acceptance edge
    logic                 lat_wr_q;
    logic [2:0]           lat_bg_q;
    logic [1:0]           lat_bank_q;
    logic [15:0]          lat_row_q;
    logic [7:0]           lat_col_q;

    // Registered command bus and its next values
    logic [3:0]           cmd_q, cmd_d;
    logic [2:0]           cmd_bg_q, cmd_bg_d;
    logic [1:0]           cmd_bank_q, cmd_bank_d;
    logic [15:0]          cmd_row_q, cmd_row_d;
    logic [7:0]           cmd_col_q, cmd_col_d;
    logic                 cmd_valid_q, done_q, ref_ack_q, busy_q;

    // ACT0 is issued on the acceptance edge itself, before the latches hold
    // the new request, so the field source bypasses to the live inputs then.
    logic                 wr_sel;
    logic [2:0]           bg_sel;
    logic [1:0]           bank_sel;
    logic [15:0]          row_sel;
    logic [7:0]           col_sel;

    assign req_ready = (state_q == S_IDLE) && !ref_req && !reset;

    // ------------------------------------------------------------------
    // Next-state and counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ref_req) begin
                    state_d = S_REF;
                    cnt_d   = C_LD_RFC;
                end else if (req_valid) begin
                    accept  = 1'b1;
                    state_d = S_ACT0;
                    cnt_d   = C_LD_RCD;
                end
            end
            S_ACT0: state_d = S_ACT1;
            S_ACT1, S_WAIT_RCD: begin
                if (cnt_q == '0) begin
                    state_d = S_CAS0;
                    cnt_d   = lat_wr_q ? C_LD_WPRE : C_LD_RPRE;
                end else begin
                    state_d = S_WAIT_RCD;
                end
            end
            S_CAS0: state_d = S_CAS1;
            S_CAS1, S_WAIT_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_PRE;
                    cnt_d   = C_LD_RP;
                end else begin
                    state_d = S_WAIT_PRE;
                end
            end
            S_PRE, S_WAIT_RP: begin
                state_d = (cnt_q == '0) ? S_IDLE : S_WAIT_RP;
            end
            S_REF, S_WAIT_RFC: begin
                state_d = (cnt_q == '0) ? S_IDLE : S_WAIT_RFC;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command bus decode from the next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_sel     = accept ? (req_op == 2'd1) : lat_wr_q;
        bg_sel     = accept ? req_bg   : lat_bg_q;
        bank_sel   = accept ? req_bank : lat_bank_q;
        row_sel    = accept ? req_row  : lat_row_q;
        col_sel    = accept ? req_col  : lat_col_q;
        cmd_d      = C_CMD_NOP;
        cmd_bg_d   = '0;
        cmd_bank_d = '0;
        cmd_row_d  = '0;
        cmd_col_d  = '0;
        case (state_d)
            S_ACT0, S_ACT1: begin
                cmd_d      = (state_d == S_ACT0) ? C_CMD_ACT0 : C_CMD_ACT1;
                cmd_bg_d   = bg_sel;
                cmd_bank_d = bank_sel;
                cmd_row_d  = row_sel;
            end
            S_CAS0: begin
                cmd_d      = wr_sel ? C_CMD_WR0 : C_CMD_RD0;
                cmd_bg_d   = bg_sel;
                cmd_bank_d = bank_sel;
                cmd_col_d  = col_sel;
            end
            S_CAS1: begin
                cmd_d      = wr_sel ? C_CMD_WR1 : C_CMD_RD1;
                cmd_bg_d   = bg_sel;
                cmd_bank_d = bank_sel;
                cmd_col_d  = col_sel;
            end
            S_PRE: begin
                cmd_d      = C_CMD_PRE;
                cmd_bg_d   = bg_sel;
                cmd_bank_d = bank_sel;
            end
            S_REF: cmd_d = C_CMD_REF;
            default: cmd_d = C_CMD_NOP;
        endcase
    end

    // ------------------------------------------------------------------
    // State, latches and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lat_wr_q    <= 1'b0;
            lat_bg_q    <= '0;
            lat_bank_q  <= '0;
            lat_row_q   <= '0;
            lat_col_q   <= '0;
            cmd_q       <= C_CMD_NOP;
            cmd_bg_q    <= '0;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ref_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                lat_wr_q   <= (req_op == 2'd1);
                lat_bg_q   <= req_bg;
                lat_bank_q <= req_bank;
                lat_row_q  <= req_row;
                lat_col_q  <= req_col;
            end
            cmd_q       <= cmd_d;
            cmd_bg_q    <= cmd_bg_d;
            cmd_bank_q  <= cmd_bank_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            cmd_valid_q <= (cmd_d != C_CMD_NOP);
            done_q      <= (state_d == S_PRE);
            ref_ack_q   <= (state_d == S_REF);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign cmd       = cmd_q;
    assign cmd_bg    = cmd_bg_q;
    assign cmd_bank  = cmd_bank_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign cmd_valid = cmd_valid_q;
    assign done      = done_q;
    assign ref_ack   = ref_ack_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr5_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr5_cmd_sequencer
// Description : Scoreboard bench for ddr5_cmd_sequencer. Each request or
//               refresh is scheduled on a transaction-level timeline when it
//               is presented; the resulting commands are queued and a
//               monitor compares the bus every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr5_cmd_sequencer;

    localparam int T_RCD   = 4;
    localparam int T_RTP   = 3;
    localparam int T_CWL   = 3;
    localparam int T_BURST = 2;
    localparam int T_WR    = 5;
    localparam int T_RP    = 4;
    localparam int T_RFC   = 10;
    localparam int NCYC    = 20000;
    localparam int WAIT_MAX = 2000;

    localparam logic [3:0] K_ACT0 = 4'd1, K_ACT1 = 4'd2, K_RD0 = 4'd3,
                           K_RD1 = 4'd4, K_WR0 = 4'd5, K_WR1 = 4'd6,
                           K_PRE = 4'd7, K_REF = 4'd8;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_bg;
    logic [1:0]  req_bank;
    logic [15:0] req_row;
    logic [7:0]  req_col;
    logic        ref_req;
    logic        ref_ack;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [7:0]  cmd_col;
    logic        done;
    logic        busy;

    ddr5_cmd_sequencer #(
        .T_RCD(T_RCD), .T_RTP(T_RTP), .T_CWL(T_CWL), .T_BURST(T_BURST),
        .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .done(done), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Reference timeline
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        logic [3:0]  kind;
        logic [2:0]  bg;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [7:0]  col;
    } exp_t;

    exp_t exp_q[$];
    bit   busy_exp [0:NCYC-1];
    int   idle_from = 0;     // first cycle the sequencer sits in IDLE again
    int   n_checks  = 0;
    int   n_pass    = 0;

    function automatic void push(int c, logic [3:0] k, logic [2:0] bg,
                                 logic [1:0] bank, logic [15:0] row, logic [7:0] col);
        exp_t e;
        e.cyc = c; e.kind = k; e.bg = bg; e.bank = bank; e.row = row; e.col = col;
        exp_q.push_back(e);
    endfunction

    function automatic void mark_busy(int from, int upto);
        for (int k = from; k < upto && k < NCYC; k++) busy_exp[k] = 1'b1;
    endfunction

    // Request presented from cycle t: accepted at the first IDLE cycle.
    function automatic void sched_req(int t, logic [1:0] op, logic [2:0] bg,
                                      logic [1:0] bank, logic [15:0] row, logic [7:0] col);
        int c, a, r, p;
        bit wr;
        wr = (op == 2'd1);
        c  = (t > idle_from) ? t : idle_from;
        a  = c + 1;
        r  = a + T_RCD;
        p  = wr ? r + T_CWL + T_BURST + T_WR : r + T_RTP;
        push(a,     K_ACT0, bg, bank, row, 8'h0);
        push(a + 1, K_ACT1, bg, bank, row, 8'h0);
        push(r,     wr ? K_WR0 : K_RD0, bg, bank, 16'h0, col);
        push(r + 1, wr ? K_WR1 : K_RD1, bg, bank, 16'h0, col);
        push(p,     K_PRE, bg, bank, 16'h0, 8'h0);
        mark_busy(a, p + T_RP - 1);
        idle_from = p + T_RP - 1;
    endfunction

    function automatic void sched_ref(int t);
        int c, f;
        c = (t > idle_from) ? t : idle_from;
        f = c + 1;
        push(f, K_REF, 3'h0, 2'h0, 16'h0, 8'h0);
        mark_busy(f, f + T_RFC - 1);
        idle_from = f + T_RFC - 1;
    endfunction

    // Reset held during cycle k: everything scheduled after k is abandoned.
    function automatic void model_reset(int k);
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > k) void'(exp_q.pop_back());
        for (int j = k + 1; j < NCYC; j++) busy_exp[j] = 1'b0;
        idle_from = k + 1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare the bus against the timeline on every negedge
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clock);
            if (cyc >= 1) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    n_checks++;
                    $display("FAIL missed_cmd cycle %0d: got none expected cmd %0d at cycle %0d",
                             cyc, exp_q[0].kind, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("cmd",       32'(cmd), 32'(e.kind));
                    check("cmd_valid", 32'(cmd_valid), 32'd1);
                    check("bg_bank",   32'({cmd_bg, cmd_bank}), 32'({e.bg, e.bank}));
                    check("row",       32'(cmd_row), 32'(e.row));
                    check("col",       32'(cmd_col), 32'(e.col));
                    check("done",      32'(done), 32'(e.kind == K_PRE));
                    check("ref_ack",   32'(ref_ack), 32'(e.kind == K_REF));
                end else begin
                    check("idle_bus", 32'({cmd_valid, cmd, done, ref_ack}), 32'd0);
                    check("idle_fields", 32'({cmd_bg, cmd_bank, cmd_row, cmd_col}), 32'd0);
                end
                check("busy", 32'(busy), 32'(busy_exp[cyc]));
                check("req_ready", 32'(req_ready),
                      32'(!reset && !busy_exp[cyc] && !ref_req));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers; all input changes happen 1 time unit after posedge
    // ------------------------------------------------------------------
    task automatic step(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic scramble_fields();
        req_op   = 2'($urandom);
        req_bg   = 3'($urandom);
        req_bank = 2'($urandom);
        req_row  = 16'($urandom);
        req_col  = 8'($urandom);
    endtask

    task automatic present_req(logic [1:0] op, logic [2:0] bg, logic [1:0] bank,
                               logic [15:0] row, logic [7:0] col);
        req_op = op; req_bg = bg; req_bank = bank; req_row = row; req_col = col;
        req_valid = 1'b1;
        sched_req(cyc, op, bg, bank, row, col);
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        while (n < WAIT_MAX) begin
            @(negedge clock);
            if (req_ready) break;
            n++;
        end
        if (n >= WAIT_MAX) begin
            n_checks++;
            $display("FAIL accept_timeout cycle %0d: got no req_ready expected one within %0d", cyc, WAIT_MAX);
        end
        step(1);
        req_valid = 1'b0;
        scramble_fields();
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (n < WAIT_MAX) begin
            @(negedge clock);
            if (ref_ack) break;
            n++;
        end
        if (n >= WAIT_MAX) begin
            n_checks++;
            $display("FAIL ack_timeout cycle %0d: got no ref_ack expected one within %0d", cyc, WAIT_MAX);
        end
        step(1);
        ref_req = 1'b0;
    endtask

    task automatic do_req(logic [1:0] op, logic [2:0] bg, logic [1:0] bank,
                          logic [15:0] row, logic [7:0] col);
        present_req(op, bg, bank, row, col);
        wait_accept();
    endtask

    task automatic do_ref();
        ref_req = 1'b1;
        sched_ref(cyc);
        wait_ack();
    endtask

    task automatic do_both(logic [1:0] op, logic [2:0] bg, logic [1:0] bank,
                           logic [15:0] row, logic [7:0] col);
        ref_req = 1'b1;
        sched_ref(cyc);
        present_req(op, bg, bank, row, col);
        wait_ack();
        wait_accept();
    endtask

    task automatic wait_idle();
        while (cyc < idle_from) step(1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1; req_valid = 1'b0; ref_req = 1'b0;
        req_op = '0; req_bg = '0; req_bank = '0; req_row = '0; req_col = '0;
        step(3);
        reset = 1'b0;
        idle_from = cyc;

        // Directed read with the reference fields
        do_req(2'd0, 3'd2, 2'd1, 16'h1234, 8'h56);
        wait_idle();

        // Write, then a second request waiting behind it
        do_req(2'd1, 3'd5, 2'd3, 16'hBEEF, 8'hA5);
        do_req(2'd0, 3'd1, 2'd0, 16'h0F0F, 8'h11);
        wait_idle();

        // Refresh and request together while idle: refresh wins
        do_both(2'd0, 3'd7, 2'd2, 16'hCAFE, 8'h3C);
        wait_idle();

        // Refresh raised mid-read
        do_req(2'd0, 3'd3, 2'd1, 16'h4321, 8'h99);
        step(2);
        do_ref();
        wait_idle();

        // Reset in the middle of a write, then a full read
        do_req(2'd1, 3'd6, 2'd2, 16'h7777, 8'h42);
        step(5);
        reset = 1'b1;
        model_reset(cyc);
        step(1);
        reset = 1'b0;
        do_req(2'd0, 3'd4, 2'd3, 16'h2468, 8'h13);
        wait_idle();

        // Back-to-back fetches and an illegal op
        do_req(2'd2, 3'd1, 2'd1, 16'h1111, 8'h01);
        do_req(2'd2, 3'd2, 2'd2, 16'h2222, 8'h02);
        do_req(2'd2, 3'd3, 2'd3, 16'h3333, 8'h03);
        do_req(2'd3, 3'd4, 2'd0, 16'h4444, 8'h04);
        wait_idle();

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 5)
                do_req(2'($urandom_range(0, 3)), 3'($urandom), 2'($urandom),
                       16'($urandom), 8'($urandom));
            else if (kind < 7)
                do_ref();
            else if (kind < 8)
                do_both(2'($urandom_range(0, 3)), 3'($urandom), 2'($urandom),
                        16'($urandom), 8'($urandom));
            else begin
                do_req(2'($urandom_range(0, 3)), 3'($urandom), 2'($urandom),
                       16'($urandom), 8'($urandom));
                step($urandom_range(0, 15));
                do_ref();
            end
            step($urandom_range(0, 3));
        end

        wait_idle();
        step(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle %0d: got no completion expected finish", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
